// File: rtl/hex_sum_bcd_display_if.sv
// hex_sum_bcd_display_if
//
// Bundles the conversion handshake, the result and the display drive of
// hex_sum_bcd_display so that the block and its driver share one port.
//
// Signals:
//   start   driver -> block  request conversion of bin_in
//   bin_in  driver -> block  7-bit binary value (0..127)
//   busy    block -> driver  conversion in progress
//   done    block -> driver  single-cycle pulse when bcd updates
//   bcd     block -> driver  {hundreds, tens, ones}, last completed result
//   seg     block -> driver  {g,f,e,d,c,b,a}, active-low segments
//   an      block -> driver  active-low digit enables (an[0] = ones)
//
// Modports:
//   master  the producer of start/bin_in (upstream stage or testbench)
//   slave   the converter/display block itself
interface hex_sum_bcd_display_if;
    logic        start;
    logic [6:0]  bin_in;
    logic        busy;
    logic        done;
    logic [11:0] bcd;
    logic [6:0]  seg;
    logic [2:0]  an;

    modport master (
        output start, bin_in,
        input  busy, done, bcd, seg, an
    );

    modport slave (
        input  start, bin_in,
        output busy, done, bcd, seg, an
    );
endinterface

// File: rtl/hex_sum_bcd_display.sv
// hex_sum_bcd_display
//
// Converts the 7-bit digit sum (0..127) into three BCD digits with an
// iterative shift-add-3 (double-dabble) engine, holds the last completed
// result, and scans it onto a 3-digit active-low 7-segment display with
// leading-zero blanking.
//
// Parameters:
//   SCAN_DIV  cycles each digit stays enabled before the scan advances
//
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous, active-high reset
//   bus  hex_sum_bcd_display_if.slave:
//          start/bin_in in, busy/done/bcd/seg/an out
module hex_sum_bcd_display #(
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    hex_sum_bcd_display_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [6:0]  SEG_BLANK = 7'b1111111;
    localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

    // ------------------------------------------------------------------
    // Conversion engine
    // ------------------------------------------------------------------
    state_t      state;
    logic        busy_q;
    logic        done_q;
    logic [11:0] bcd_q;
    logic [11:0] scratch;      // BCD accumulator being built
    logic [6:0]  shreg;        // binary bits still to be shifted in
    logic [2:0]  count;        // shifts remaining

    logic [11:0] adjusted;
    logic [11:0] scratch_next;

    // Add 3 to every nibble >= 5 so that the following left shift
    // carries correctly into the next decimal digit.
    always_comb begin
        // NOTE: every always_comb output gets a default first so that no
        // path leaves it unassigned and a latch is never inferred.
        adjusted = scratch;
        for (int i = 0; i < 3; i++) begin
            if (scratch[i*4 +: 4] >= 4'd5) begin
                adjusted[i*4 +: 4] = scratch[i*4 +: 4] + 4'd3;
            end
        end
        scratch_next = {adjusted[10:0], shreg[6]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bcd_q   <= 12'h000;
            scratch <= 12'h000;
            shreg   <= 7'd0;
            count   <= 3'd0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // register samples the pre-edge values of its neighbours.
            done_q <= 1'b0;
            case (state)
                // DONE accepts start like IDLE so conversions can run
                // back to back without an idle gap.
                ST_IDLE, ST_DONE: begin
                    busy_q <= 1'b0;
                    if (bus.start) begin
                        shreg   <= bus.bin_in;
                        scratch <= 12'h000;
                        count   <= 3'd7;
                        busy_q  <= 1'b1;
                        state   <= ST_SHIFT;
                    end else begin
                        state <= ST_IDLE;
                    end
                end

                ST_SHIFT: begin
                    scratch <= scratch_next;
                    shreg   <= {shreg[5:0], 1'b0};
                    count   <= count - 3'd1;
                    // The 7th shift publishes its own result directly so
                    // bcd is valid on the same edge that enters DONE.
                    if (count == 3'd1) begin
                        bcd_q  <= scratch_next;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= ST_DONE;
                    end
                end

                default: begin
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Display scan
    // ------------------------------------------------------------------
    logic [15:0] scan_cnt;
    logic [1:0]  digit_idx;
    logic [1:0]  idx_next;
    logic [6:0]  seg_q;
    logic [2:0]  an_q;

    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] code;
        case (digit)
            4'd0:    code = 7'b1000000;
            4'd1:    code = 7'b1111001;
            4'd2:    code = 7'b0100100;
            4'd3:    code = 7'b0110000;
            4'd4:    code = 7'b0011001;
            4'd5:    code = 7'b0010010;
            4'd6:    code = 7'b0000010;
            4'd7:    code = 7'b1111000;
            4'd8:    code = 7'b0000000;
            4'd9:    code = 7'b0010000;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

    // Segment pattern for one digit slot, with leading zeros blanked.
    // Ones always shows; tens blanks only when hundreds is also zero.
    function automatic logic [6:0] slot_seg(input logic [1:0]  idx,
                                            input logic [11:0] value);
        logic [3:0] hun;
        logic [3:0] ten;
        logic [3:0] one;
        logic [6:0] code;
        hun = value[11:8];
        ten = value[7:4];
        one = value[3:0];
        case (idx)
            2'd1:    code = (hun == 4'd0 && ten == 4'd0) ? SEG_BLANK : seg_encode(ten);
            2'd2:    code = (hun == 4'd0) ? SEG_BLANK : seg_encode(hun);
            default: code = seg_encode(one);
        endcase
        return code;
    endfunction

    function automatic logic [2:0] an_decode(input logic [1:0] idx);
        logic [2:0] enables;
        case (idx)
            2'd1:    enables = 3'b101;
            2'd2:    enables = 3'b011;
            default: enables = 3'b110;
        endcase
        return enables;
    endfunction

    assign idx_next = (digit_idx == 2'd2) ? 2'd0 : digit_idx + 2'd1;

    // seg and an are loaded together only on the wrap edge, so a bcd
    // update mid-scan appears at the next digit change and never splits
    // a digit slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt  <= 16'd0;
            digit_idx <= 2'd0;
            an_q      <= 3'b110;
            seg_q     <= 7'b1000000;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt  <= 16'd0;
            digit_idx <= idx_next;
            an_q      <= an_decode(idx_next);
            seg_q     <= slot_seg(idx_next, bcd_q);
        end else begin
            scan_cnt <= scan_cnt + 16'd1;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.bcd  = bcd_q;
    assign bus.seg  = seg_q;
    assign bus.an   = an_q;

endmodule

// File: tb/tb_hex_sum_bcd_display.sv
// tb_hex_sum_bcd_display
//
// Self-checking bench for hex_sum_bcd_display: a table of conversions with
// hand-computed BCD results and handshake timing, followed by hand-written
// sequences for start-while-busy, back-to-back start in DONE, reset
// mid-conversion and the display scan with leading-zero blanking.
module tb_hex_sum_bcd_display;

    localparam int SCAN_DIV = 4;

    logic clk;
    logic rst;

    hex_sum_bcd_display_if bus ();

    hex_sum_bcd_display #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;

    typedef struct {
        logic [6:0]  bin;
        logic [11:0] exp_bcd;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Reference segment code for a decimal digit, gfedcba active-low.
    function automatic logic [6:0] ref_seg(input logic [3:0] d);
        logic [6:0] tbl [10];
        tbl[0] = 7'b1000000; tbl[1] = 7'b1111001; tbl[2] = 7'b0100100;
        tbl[3] = 7'b0110000; tbl[4] = 7'b0011001; tbl[5] = 7'b0010010;
        tbl[6] = 7'b0000010; tbl[7] = 7'b1111000; tbl[8] = 7'b0000000;
        tbl[9] = 7'b0010000;
        return (d <= 4'd9) ? tbl[d] : 7'b1111111;
    endfunction

    // Expected seg for slot idx (0=ones, 1=tens, 2=hundreds) of value v.
    function automatic logic [6:0] ref_slot(input int idx, input logic [11:0] v);
        if (idx == 2) return (v[11:8] == 4'd0) ? 7'b1111111 : ref_seg(v[11:8]);
        if (idx == 1) return (v[11:8] == 4'd0 && v[7:4] == 4'd0) ? 7'b1111111 : ref_seg(v[7:4]);
        return ref_seg(v[3:0]);
    endfunction

    function automatic logic [2:0] ref_an(input int idx);
        if (idx == 1) return 3'b101;
        if (idx == 2) return 3'b011;
        return 3'b110;
    endfunction

    // Caller has set start/bin_in before a rising edge. That edge accepts
    // the request; busy must read 1 over the next 7 cycles and done/bcd
    // must appear in the 8th. With hold=1, start stays high with bin_in=99
    // through the busy window to show it is ignored. Returns at the
    // negedge of the done cycle.
    task automatic conv_tail(input string name, input logic [11:0] exp_bcd,
                             input bit hold);
        @(posedge clk);
        #1;
        if (hold) begin
            bus.bin_in = 7'd99;
        end else begin
            bus.start  = 1'b0;
            bus.bin_in = 7'h55;   // changes after acceptance must not matter
        end
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            check({name, " busy"}, {30'd0, bus.busy, bus.done}, 32'b10);
            if (i == 7) bus.start = 1'b0;
        end
        @(negedge clk);
        check({name, " done"}, {30'd0, bus.busy, bus.done}, 32'b01);
        check({name, " bcd"}, {20'd0, bus.bcd}, {20'd0, exp_bcd});
    endtask

    task automatic run_conv(input string name, input logic [6:0] bin,
                            input logic [11:0] exp_bcd);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bin_in = bin;
        conv_tail(name, exp_bcd, 1'b0);
        @(negedge clk);
        check({name, " done drops"}, {31'd0, bus.done}, 32'd0);
    endtask

    // Locks onto a digit change, then checks an/seg each cycle for the
    // given number of digit periods against the expected value v.
    task automatic disp_check(input string name, input logic [11:0] v,
                              input int periods);
        logic [2:0] prev_an;
        bit         seen;
        int         pos;
        seen = 1'b0;
        @(negedge clk);
        prev_an = bus.an;
        for (int k = 0; k < 4 * SCAN_DIV && !seen; k++) begin
            @(negedge clk);
            if (bus.an !== prev_an) seen = 1'b1;
            prev_an = bus.an;
        end
        check({name, " scan advances"}, {31'd0, seen}, 32'd1);
        if (!seen) return;
        case (bus.an)
            3'b110:  pos = 0;
            3'b101:  pos = 1;
            3'b011:  pos = 2;
            default: pos = -1;
        endcase
        check({name, " an one-hot-low"}, {31'd0, pos >= 0}, 32'd1);
        if (pos < 0) return;
        for (int p = 0; p < periods; p++) begin
            int idx;
            idx = (pos + p) % 3;
            for (int c = 0; c < SCAN_DIV; c++) begin
                if (p != 0 || c != 0) @(negedge clk);
                check($sformatf("%s slot%0d cyc%0d an/seg", name, idx, c),
                      {22'd0, bus.an, bus.seg},
                      {22'd0, ref_an(idx), ref_slot(idx, v)});
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit saw_done;
        total = 0;
        bad   = 0;

        vecs[0] = '{7'd0,   12'h000};
        vecs[1] = '{7'd9,   12'h009};
        vecs[2] = '{7'd10,  12'h010};
        vecs[3] = '{7'd45,  12'h045};
        vecs[4] = '{7'd99,  12'h099};
        vecs[5] = '{7'd100, 12'h100};
        vecs[6] = '{7'd120, 12'h120};
        vecs[7] = '{7'd127, 12'h127};
        vecs[8] = '{7'd64,  12'h064};
        vecs[9] = '{7'd5,   12'h005};

        // Reset state
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.bin_in = 7'd0;
        #23;
        check("reset busy/done", {30'd0, bus.busy, bus.done}, 32'd0);
        check("reset bcd", {20'd0, bus.bcd}, 32'h000);
        check("reset an", {29'd0, bus.an}, 32'b110);
        check("reset seg", {25'd0, bus.seg}, 32'b1000000);
        @(negedge clk);
        rst = 1'b0;

        // Table of conversions
        foreach (vecs[i]) begin
            run_conv($sformatf("vec%0d(%0d)", i, vecs[i].bin),
                     vecs[i].bin, vecs[i].exp_bcd);
        end

        // 127 then 0, and the display of 000
        run_conv("max127", 7'd127, 12'h127);
        run_conv("zero", 7'd0, 12'h000);
        repeat (3 * SCAN_DIV) @(negedge clk);
        disp_check("disp000", 12'h000, 3);

        // start held through busy is ignored; back-to-back start in DONE
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bin_in = 7'd45;
        conv_tail("hold45", 12'h045, 1'b1);
        bus.start  = 1'b1;
        bus.bin_in = 7'd9;
        conv_tail("b2b9", 12'h009, 1'b0);
        @(negedge clk);
        check("b2b9 done drops", {31'd0, bus.done}, 32'd0);
        repeat (3 * SCAN_DIV) @(negedge clk);
        disp_check("disp009", 12'h009, 3);

        // Reset 3 cycles into the conversion of 88
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bin_in = 7'd88;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort busy before rst", {31'd0, bus.busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("abort busy/done", {30'd0, bus.busy, bus.done}, 32'd0);
        check("abort bcd", {20'd0, bus.bcd}, 32'h000);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) saw_done = 1'b1;
        end
        check("abort no done after", {31'd0, saw_done}, 32'd0);

        // Display scan with hundreds non-zero, then hundreds blank
        run_conv("c105", 7'd105, 12'h105);
        repeat (3 * SCAN_DIV) @(negedge clk);
        disp_check("disp105", 12'h105, 6);

        run_conv("c37", 7'd37, 12'h037);
        repeat (3 * SCAN_DIV) @(negedge clk);
        disp_check("disp037", 12'h037, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
